// File: rtl/block_tx_serializer.sv
// Block-to-byte serializer for the UART transmit path: one active block being
// shifted out a byte at a time plus one pending block for gap-free streaming.
module block_tx_serializer #(
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned NUM_BYTES = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                                 clk_100MHz,
    input  logic                                 reset,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0]          load_data,
    input  logic                                 abort,
    output logic [BYTE_W-1:0]                    tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic [$clog2(NUM_BYTES+1)-1:0]       bytes_left,
    output logic                                 busy,
    output logic                                 empty,
    output logic                                 overrun
);

    localparam int unsigned BLK_W = BYTE_W * NUM_BYTES;
    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic               empty_q, empty_d;
    logic               overrun_q, overrun_d;

    logic               load_acc;
    logic               byte_xfer;
    logic               last_xfer;
    logic [BLK_W-1:0]   shift_next;

    // Outputs come straight from flops; the active flag is the SEND state.
    assign tx_valid   = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign bytes_left = cnt_q;
    assign empty      = empty_q;
    assign overrun    = overrun_q;
    assign load_ready = !pend_valid_q;
    assign tx_data    = (MSB_FIRST != 0) ? shift_q[BLK_W-1 -: BYTE_W]
                                         : shift_q[BYTE_W-1:0];

    // Handshake qualifiers and the byte-advanced view of the shift register.
    always_comb begin
        load_acc   = load_valid && !pend_valid_q;
        byte_xfer  = (state_q == SEND) && tx_ready;
        last_xfer  = byte_xfer && (cnt_q == CNT_W'(1));
        shift_next = (MSB_FIRST != 0)
                   ? {shift_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)}
                   : {BYTE_W'(0), shift_q[BLK_W-1:BYTE_W]};
    end

    // Next-state: byte advance, block completion/promotion, load steering, abort.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = load_valid && pend_valid_q;

        if (abort) begin
            state_d      = IDLE;
            shift_d      = '0;
            cnt_d        = '0;
            pend_d       = '0;
            pend_valid_d = 1'b0;
        end else begin
            if (last_xfer) begin
                if (pend_valid_q) begin
                    shift_d      = pend_q;
                    cnt_d        = CNT_W'(NUM_BYTES);
                    pend_valid_d = 1'b0;
                end else if (load_acc) begin
                    shift_d = load_data;
                    cnt_d   = CNT_W'(NUM_BYTES);
                end else begin
                    state_d = IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end else if (byte_xfer) begin
                shift_d = shift_next;
                cnt_d   = cnt_q - CNT_W'(1);
            end

            // A load completing alongside the last byte was handled above.
            if (load_acc && !last_xfer) begin
                if (state_q == IDLE) begin
                    state_d = SEND;
                    shift_d = load_data;
                    cnt_d   = CNT_W'(NUM_BYTES);
                end else begin
                    pend_d       = load_data;
                    pend_valid_d = 1'b1;
                end
            end
        end

        empty_d = (state_d == IDLE) && !pend_valid_d;
    end

    // State and datapath registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            empty_q      <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            empty_q      <= empty_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_block_tx_serializer.sv
// Directed bench for block_tx_serializer: MSB-first and LSB-first instances
// share stimulus; a byte scoreboard per instance checks every transfer.
module tb_block_tx_serializer;

    localparam int unsigned BW = 8;
    localparam int unsigned NB = 8;
    localparam int unsigned DW = BW * NB;
    localparam int unsigned CW = $clog2(NB + 1);

    typedef struct packed {
        logic [BW-1:0] data;
        logic [CW-1:0] left;
    } exp_t;

    logic          clk_100MHz = 1'b0;
    logic          reset      = 1'b1;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data  = '0;
    logic          abort      = 1'b0;
    logic          tx_ready   = 1'b0;

    logic          load_ready, tx_valid, busy, empty, overrun;
    logic [BW-1:0] tx_data;
    logic [CW-1:0] bytes_left;
    logic          l_load_ready, l_tx_valid, l_busy, l_empty, l_overrun;
    logic [BW-1:0] l_tx_data;
    logic [CW-1:0] l_bytes_left;

    exp_t q_m[$];
    exp_t q_l[$];
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    block_tx_serializer #(.BYTE_W(BW), .NUM_BYTES(NB), .MSB_FIRST(1)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .abort(abort), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bytes_left(bytes_left), .busy(busy), .empty(empty), .overrun(overrun)
    );

    block_tx_serializer #(.BYTE_W(BW), .NUM_BYTES(NB), .MSB_FIRST(0)) dut_lsb (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .load_valid(load_valid), .load_ready(l_load_ready), .load_data(load_data),
        .abort(abort), .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(tx_ready),
        .bytes_left(l_bytes_left), .busy(l_busy), .empty(l_empty), .overrun(l_overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    // Expected byte stream for both byte orders.
    task automatic push_block(input logic [DW-1:0] d);
        exp_t e;
        for (int k = 0; k < int'(NB); k++) begin
            e.left = CW'(NB - k);
            e.data = d[DW-1-BW*k -: BW];
            q_m.push_back(e);
            e.data = d[BW*k+BW-1 -: BW];
            q_l.push_back(e);
        end
    endtask

    // One-cycle load that the bench expects to be accepted.
    task automatic load_block(input string tag, input logic [DW-1:0] d);
        chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
        load_valid = 1'b1;
        load_data  = d;
        push_block(d);
        tick();
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx_valid"},   64'(tx_valid),     64'd0);
        chk({tag, "_busy"},       64'(busy),         64'd0);
        chk({tag, "_bytes_left"}, 64'(bytes_left),   64'd0);
        chk({tag, "_empty"},      64'(empty),        64'd1);
        chk({tag, "_overrun"},    64'(overrun),      64'd0);
        chk({tag, "_load_ready"}, 64'(load_ready),   64'd1);
        chk({tag, "_tx_data"},    64'(tx_data),      64'd0);
        chk({tag, "_l_tx_valid"}, 64'(l_tx_valid),   64'd0);
        chk({tag, "_l_busy"},     64'(l_busy),       64'd0);
        chk({tag, "_l_left"},     64'(l_bytes_left), 64'd0);
        chk({tag, "_l_empty"},    64'(l_empty),      64'd1);
        chk({tag, "_l_overrun"},  64'(l_overrun),    64'd0);
        chk({tag, "_l_ready"},    64'(l_load_ready), 64'd1);
        chk({tag, "_l_tx_data"},  64'(l_tx_data),    64'd0);
    endtask

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 60; i++) begin
            if (q_m.size() == 0 && q_l.size() == 0 && !tx_valid && !l_tx_valid) break;
            tick();
        end
        chk({tag, "_drain_in_budget"}, 64'(i < 60), 64'd1);
        chk({tag, "_q_m_left"}, 64'(q_m.size()), 64'd0);
        chk({tag, "_q_l_left"}, 64'(q_l.size()), 64'd0);
        chk_idle(tag);
    endtask

    // Scoreboard: every transfer handshake is checked against the next expected byte.
    always @(negedge clk_100MHz) begin
        exp_t e;
        if (!reset && !abort) begin
            if (tx_valid && tx_ready) begin
                if (q_m.size() == 0) chk("msb_unexpected_byte", 64'(tx_data), 64'hFFFF_FFFF);
                else begin
                    e = q_m.pop_front();
                    chk("msb_byte", 64'(tx_data), 64'(e.data));
                    chk("msb_left", 64'(bytes_left), 64'(e.left));
                end
            end
            if (l_tx_valid && tx_ready) begin
                if (q_l.size() == 0) chk("lsb_unexpected_byte", 64'(l_tx_data), 64'hFFFF_FFFF);
                else begin
                    e = q_l.pop_front();
                    chk("lsb_byte", 64'(l_tx_data), 64'(e.data));
                    chk("lsb_left", 64'(l_bytes_left), 64'(e.left));
                end
            end
        end
    end

    initial begin
        logic [BW-1:0] hold_data;
        logic [CW-1:0] hold_left;

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("post_reset");

        // Single block, both byte orders, one-cycle latency
        tx_ready = 1'b1;
        load_block("single", 64'h0123456789ABCDEF);
        chk("single_latency_valid", 64'(tx_valid), 64'd1);
        chk("single_first_left", 64'(bytes_left), 64'd8);
        chk("single_first_byte", 64'(tx_data), 64'h01);
        chk("single_first_lbyte", 64'(l_tx_data), 64'hEF);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("single_valid_run", 64'(tx_valid), 64'd1);
        end
        tick();
        chk_idle("single_end");

        // Back-to-back blocks: pending loaded during A's third byte
        load_block("b2b_a", 64'h1122334455667788);
        tick();
        tick();
        load_block("b2b_b", 64'hFEDCBA9876543210);
        for (int i = 0; i < 13; i++) begin
            chk("b2b_no_gap", 64'(tx_valid), 64'd1);
            chk("b2b_load_ready", 64'(load_ready), 64'(i >= 5));
            tick();
        end
        chk("b2b_q_m_done", 64'(q_m.size()), 64'd0);
        chk_idle("b2b_end");

        // Backpressure mid-block
        load_block("bp", 64'hA0A1A2A3A4A5A6A7);
        tick();
        tick();
        tx_ready  = 1'b0;
        hold_data = q_m[0].data;
        hold_left = q_m[0].left;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(tx_valid), 64'd1);
            chk("bp_data_stable", 64'(tx_data), 64'(hold_data));
            chk("bp_left_stable", 64'(bytes_left), 64'(hold_left));
        end
        tx_ready = 1'b1;
        drain("bp");

        // Overrun: A active and stalled, B pending, C refused three times
        tx_ready = 1'b0;
        load_block("ovr_a", 64'h0F1E2D3C4B5A6978);
        load_block("ovr_b", 64'h8877665544332211);
        chk("ovr_ready_low", 64'(load_ready), 64'd0);
        load_valid = 1'b1;
        load_data  = 64'hC0C0C0C0C0C0C0C0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovr_pulse", 64'(overrun), 64'd1);
            chk("ovr_l_pulse", 64'(l_overrun), 64'd1);
            chk("ovr_still_full", 64'(load_ready), 64'd0);
        end
        load_valid = 1'b0;
        load_data  = '0;
        tick();
        chk("ovr_pulse_end", 64'(overrun), 64'd0);
        tx_ready = 1'b1;
        drain("ovr");

        // Abort during byte 4 of A with B pending
        load_block("abt_a", 64'h0102030405060708);
        tick();
        tick();
        load_block("abt_b", 64'h1112131415161718);
        chk("abt_pending_full", 64'(load_ready), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
        q_m.delete();
        q_l.delete();
        load_block("abt_fresh", 64'h2468ACE013579BDF);
        drain("abt_fresh");

        // Asynchronous reset mid-block
        load_block("rst_a", 64'h5555AAAA3333CCCC);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_idle("reset_mid");
        q_m.delete();
        q_l.delete();
        tick();
        reset = 1'b0;
        tick();
        load_block("rst_fresh", 64'hDEADBEEFCAFEF00D);
        drain("rst_fresh");

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
